// File: rtl/pipe_parity_check_if.sv
// Word/status bundle for the pipelined parity checker.
// The master side drives received words and clears; the slave side is the checker.
interface pipe_parity_check_if #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_parity;
    logic             err_clr;
    logic             out_valid;
    logic             out_err;
    logic             err_sticky;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_data, in_parity, err_clr,
        input  out_valid, out_err, err_sticky, err_count
    );

    modport slave (
        input  in_valid, in_data, in_parity, err_clr,
        output out_valid, out_err, err_sticky, err_count
    );
endinterface

// File: rtl/pipe_parity_check.sv
// Receive-side parity checker: a registered XOR tree of 6-input groups over
// {in_parity, in_data}, with a valid bit riding alongside and sticky/saturating status.
module pipe_parity_check #(
    parameter int WIDTH = 10,
    parameter int ODD   = 0,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipe_parity_check_if.slave    bus
);
    localparam int VW = WIDTH + 1;

    function automatic int calc_lat(input int w);
        int     s;
        longint p;
        s = 1;
        p = 6;
        while (p < longint'(w)) begin
            p = p * 6;
            s = s + 1;
        end
        return s;
    endfunction

    function automatic int stage_w(input int w, input int s);
        int r;
        r = w;
        for (int i = 0; i < s; i++) r = (r + 5) / 6;
        return r;
    endfunction

    localparam int   LAT     = calc_lat(VW);
    localparam logic ODD_BIT = (ODD != 0);

    // Each stage pads its input up to whole 6-bit groups and registers one XOR per group.
    for (genvar s = 0; s < LAT; s++) begin : stg
        localparam int IW = stage_w(VW, s);
        localparam int OW = stage_w(VW, s + 1);

        logic [IW-1:0]   din;
        logic            vin;
        logic [OW*6-1:0] padded;
        logic [OW-1:0]   grp;
        logic [OW-1:0]   dout;
        logic            vout;

        if (s == 0) begin : g_first
            assign din = {bus.in_parity, bus.in_data};
            assign vin = bus.in_valid;
        end else begin : g_next
            assign din = stg[s-1].dout;
            assign vin = stg[s-1].vout;
        end

        assign padded = (OW*6)'(din);

        always_comb begin
            grp = '0;
            for (int g = 0; g < OW; g++) grp[g] = ^padded[g*6 +: 6];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout <= '0;
                vout <= 1'b0;
            end else begin
                dout <= grp;
                vout <= vin;
            end
        end
    end

    logic             out_valid;
    logic             out_err;
    logic             err_sticky;
    logic [CNT_W-1:0] err_count;

    assign out_valid = stg[LAT-1].vout;
    assign out_err   = out_valid & (stg[LAT-1].dout[0] ^ ODD_BIT);

    // A clear coinciding with a new error leaves exactly that one error recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (bus.err_clr) begin
            err_sticky <= out_err;
            err_count  <= out_err ? CNT_W'(1) : '0;
        end else if (out_err) begin
            err_sticky <= 1'b1;
            if (err_count != '1) err_count <= err_count + CNT_W'(1);
        end
    end

    assign bus.out_valid  = out_valid;
    assign bus.out_err    = out_err;
    assign bus.err_sticky = err_sticky;
    assign bus.err_count  = err_count;
endmodule

// File: tb/tb_pipe_parity_check.sv
// Bench for pipe_parity_check: three configurations, scoreboarded per word
// (error flag and arrival cycle), plus inline status-register checks.
module tb_pipe_parity_check;
    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        logic err;
        int   due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    pipe_parity_check_if #(.WIDTH(10), .CNT_W(16)) ifa ();
    pipe_parity_check_if #(.WIDTH(36), .CNT_W(16)) ifb ();
    pipe_parity_check_if #(.WIDTH(10), .CNT_W(2))  ifc ();

    pipe_parity_check #(.WIDTH(10), .ODD(0), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    pipe_parity_check #(.WIDTH(36), .ODD(1), .CNT_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    pipe_parity_check #(.WIDTH(10), .ODD(0), .CNT_W(2))  dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboards: each out_valid must match the oldest expected word and its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (qa.size() > 0 && qa[0].due < cyc) begin
                vectors++; miscompares++;
                $display("[TB] FAIL a_missing: word due at cycle %0d never appeared, now cycle %0d", qa[0].due, cyc);
                e = qa.pop_front();
            end
            vectors++;
            if (ifa.out_valid) begin
                if (qa.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL a_spurious: out_valid=1 at cycle %0d, required 0", cyc);
                end else begin
                    e = qa.pop_front();
                    if (ifa.out_err !== e.err || cyc != e.due) begin
                        miscompares++;
                        $display("[TB] FAIL a_word: got err=%b cycle=%0d, required err=%b cycle=%0d", ifa.out_err, cyc, e.err, e.due);
                    end
                end
            end else if (ifa.out_err !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL a_err_gated: out_err=%b with out_valid=0, required 0", ifa.out_err);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (qb.size() > 0 && qb[0].due < cyc) begin
                vectors++; miscompares++;
                $display("[TB] FAIL b_missing: word due at cycle %0d never appeared, now cycle %0d", qb[0].due, cyc);
                e = qb.pop_front();
            end
            vectors++;
            if (ifb.out_valid) begin
                if (qb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL b_spurious: out_valid=1 at cycle %0d, required 0", cyc);
                end else begin
                    e = qb.pop_front();
                    if (ifb.out_err !== e.err || cyc != e.due) begin
                        miscompares++;
                        $display("[TB] FAIL b_word: got err=%b cycle=%0d, required err=%b cycle=%0d", ifb.out_err, cyc, e.err, e.due);
                    end
                end
            end else if (ifb.out_err !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL b_err_gated: out_err=%b with out_valid=0, required 0", ifb.out_err);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (qc.size() > 0 && qc[0].due < cyc) begin
                vectors++; miscompares++;
                $display("[TB] FAIL c_missing: word due at cycle %0d never appeared, now cycle %0d", qc[0].due, cyc);
                e = qc.pop_front();
            end
            vectors++;
            if (ifc.out_valid) begin
                if (qc.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL c_spurious: out_valid=1 at cycle %0d, required 0", cyc);
                end else begin
                    e = qc.pop_front();
                    if (ifc.out_err !== e.err || cyc != e.due) begin
                        miscompares++;
                        $display("[TB] FAIL c_word: got err=%b cycle=%0d, required err=%b cycle=%0d", ifc.out_err, cyc, e.err, e.due);
                    end
                end
            end else if (ifc.out_err !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL c_err_gated: out_err=%b with out_valid=0, required 0", ifc.out_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [9:0] d, input logic p);
        ifa.in_valid  = v;
        ifa.in_data   = d;
        ifa.in_parity = p;
        if (v) qa.push_back('{err: ((^{p, d}) != 1'b0), due: cyc + 2});
    endtask

    task automatic drive_b(input logic v, input logic [35:0] d, input logic p);
        ifb.in_valid  = v;
        ifb.in_data   = d;
        ifb.in_parity = p;
        if (v) qb.push_back('{err: ((^{p, d}) != 1'b1), due: cyc + 3});
    endtask

    task automatic drive_c(input logic v, input logic [9:0] d, input logic p);
        ifc.in_valid  = v;
        ifc.in_data   = d;
        ifc.in_parity = p;
        if (v) qc.push_back('{err: ((^{p, d}) != 1'b0), due: cyc + 2});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_a(1'b0, '0, 1'b0); drive_b(1'b0, '0, 1'b0); drive_c(1'b0, '0, 1'b0);
        ifa.err_clr = 1'b0; ifb.err_clr = 1'b0; ifc.err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({ifa.out_valid, ifa.out_err, ifa.err_sticky, ifa.err_count} !== 19'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_a: got v=%b e=%b s=%b c=%0d, required all 0", ifa.out_valid, ifa.out_err, ifa.err_sticky, ifa.err_count);
        end
        vectors++;
        if ({ifb.out_valid, ifb.out_err, ifb.err_sticky, ifb.err_count} !== 19'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_b: got v=%b e=%b s=%b c=%0d, required all 0", ifb.out_valid, ifb.out_err, ifb.err_sticky, ifb.err_count);
        end
        vectors++;
        if ({ifc.out_valid, ifc.out_err, ifc.err_sticky, ifc.err_count} !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_c: got v=%b e=%b s=%b c=%0d, required all 0", ifc.out_valid, ifc.out_err, ifc.err_sticky, ifc.err_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_good_word();
        drive_a(1'b1, 10'h3FF, 1'b0);
        tick();
        drive_a(1'b0, '0, 1'b0);
        repeat (3) tick();
        vectors++;
        if (ifa.err_count !== 16'd0 || ifa.err_sticky !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL good_word_status: got count=%0d sticky=%b, required 0 0", ifa.err_count, ifa.err_sticky);
        end
    endtask

    task automatic test_bad_word();
        drive_a(1'b1, 10'h001, 1'b0);
        tick();
        drive_a(1'b0, '0, 1'b0);
        tick();
        vectors++;
        if (ifa.out_err !== 1'b1 || ifa.err_count !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL bad_word_pre: got out_err=%b count=%0d, required 1 0", ifa.out_err, ifa.err_count);
        end
        tick();
        vectors++;
        if (ifa.err_count !== 16'd1 || ifa.err_sticky !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bad_word_status: got count=%0d sticky=%b, required 1 1", ifa.err_count, ifa.err_sticky);
        end
    endtask

    task automatic test_gaps();
        logic [11:0] pat;
        logic [31:0] r;
        pat = 12'b1011_0100_1110;
        for (int i = 0; i < 12; i++) begin
            r = $urandom();
            drive_a(pat[i], r[9:0], r[10]);
            tick();
        end
        drive_a(1'b0, '0, 1'b0);
        repeat (4) tick();
        vectors++;
        if (qa.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL gaps_drain: got %0d words pending, required 0", qa.size());
        end
    endtask

    task automatic test_stream();
        logic [63:0] r;
        logic [35:0] d;
        logic        p;
        int          idx;
        int          nerr;
        nerr = 0;
        for (int i = 0; i < 1000; i++) begin
            r = {$urandom(), $urandom()};
            d = r[35:0];
            p = ~(^d);
            if (i % 27 == 5) begin
                idx = $urandom_range(0, 36);
                if (idx == 36) p = ~p;
                else d[idx] = ~d[idx];
                nerr++;
            end
            drive_b(1'b1, d, p);
            tick();
        end
        drive_b(1'b0, '0, 1'b0);
        repeat (5) tick();
        vectors++;
        if (ifb.err_count !== 16'(nerr) || nerr != 37) begin
            miscompares++;
            $display("[TB] FAIL stream_count: got %0d, required 37 (injected %0d)", ifb.err_count, nerr);
        end
        vectors++;
        if (ifb.err_sticky !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL stream_sticky: got %b, required 1", ifb.err_sticky);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    drive_c(1'b1, 10'h001, 1'b0);
                    tick();
                end
                drive_c(1'b0, '0, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                for (int k = 0; k < 5; k++) begin
                    #1;
                    vectors++;
                    if (ifc.err_count !== exp_cnt[k]) begin
                        miscompares++;
                        $display("[TB] FAIL saturate_%0d: got count=%0d, required %0d", k, ifc.err_count, exp_cnt[k]);
                    end
                    if (k < 4) @(posedge clk);
                end
            end
        join
        repeat (2) tick();
    endtask

    task automatic test_clear_collide();
        vectors++;
        if (ifc.err_count !== 2'd3) begin
            miscompares++;
            $display("[TB] FAIL clear_pre: got count=%0d, required 3", ifc.err_count);
        end
        drive_c(1'b1, 10'h001, 1'b0);
        tick();
        drive_c(1'b0, '0, 1'b0);
        tick();
        ifc.err_clr = 1'b1;
        tick();
        ifc.err_clr = 1'b0;
        vectors++;
        if (ifc.err_count !== 2'd1 || ifc.err_sticky !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL clear_collide: got count=%0d sticky=%b, required 1 1", ifc.err_count, ifc.err_sticky);
        end
        ifc.err_clr = 1'b1;
        tick();
        ifc.err_clr = 1'b0;
        vectors++;
        if (ifc.err_count !== 2'd0 || ifc.err_sticky !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clear_alone: got count=%0d sticky=%b, required 0 0", ifc.err_count, ifc.err_sticky);
        end
    endtask

    task automatic test_reset_mid();
        drive_a(1'b1, 10'h001, 1'b0);
        tick();
        drive_a(1'b1, 10'h007, 1'b0);
        #2;
        rst_n = 1'b0;
        qa.delete(); qb.delete(); qc.delete();
        #1;
        vectors++;
        if ({ifa.out_valid, ifa.out_err, ifa.err_sticky, ifa.err_count} !== 19'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: got v=%b e=%b s=%b c=%0d, required all 0", ifa.out_valid, ifa.out_err, ifa.err_sticky, ifa.err_count);
        end
        ifa.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        drive_a(1'b1, 10'h001, 1'b0);
        tick();
        drive_a(1'b0, '0, 1'b0);
        repeat (4) tick();
        vectors++;
        if (qa.size() != 0 || ifa.err_count !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_after: got pending=%0d count=%0d, required 0 1", qa.size(), ifa.err_count);
        end
    endtask

    initial begin
        test_reset();
        test_good_word();
        test_bad_word();
        test_gaps();
        test_stream();
        test_saturate();
        test_clear_collide();
        test_reset_mid();
        repeat (3) tick();
        vectors++;
        if (qa.size() + qb.size() + qc.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL final_drain: got %0d words pending, required 0", qa.size() + qb.size() + qc.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
